cipher_stream_reader: RTL and testbench

// - Reads ciphertext C0 (l = m*t bits) out of encrypt_col_block's internal RAM through its rd_en_c/addr_rd_c/cipher port after encryption done.
// - Serialises the 32-bit words into a byte stream over a valid/ready handshake for the encap hash/output path.
// - Sits between encrypt_col_block and the session-key hash/UART output.
// - The encryption core is idle while this block is busy; this block owns addr_1 of the cipher RAM.

---
 rtl/cipher_stream_reader.sv | 203 ++++++++++++++++++++
 tb/tb_cipher_stream_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_stream_reader.sv
// Reads the ciphertext words out of the encryption RAM and streams them MSB-first as bytes over valid/ready.
// Optional build macro CIPHER_PAD_MASK_EN zeroes the pad bits beyond l in the final byte.
module cipher_stream_reader #(
    parameter int parameter_set = 1,
    localparam int M = (parameter_set == 1) ? 12 : 13,
    localparam int T = (parameter_set == 1) ? 64 :
                       (parameter_set == 2) ? 96 :
                       (parameter_set == 4) ? 119 : 128,
    localparam int L = M * T,
    localparam int RAM_DEPTH = (L + 31) / 32,
    localparam int N_BYTES = (L + 7) / 8,
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en_c,
    output logic [AW-1:0] addr_rd_c,
    input  logic [31:0]   cipher,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    localparam int WCW = AW + 1;
    localparam int BCW = $clog2(N_BYTES) + 1;
    localparam int TAIL_BITS = L % 32;
    localparam int LAST_WORD_BYTES = (TAIL_BITS == 0) ? 4 : (TAIL_BITS + 7) / 8;

    localparam logic [WCW-1:0] LAST_WORD = WCW'(RAM_DEPTH - 1);
    localparam logic [1:0]     LAST_SLOT = 2'(LAST_WORD_BYTES - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(N_BYTES - 1);

`ifdef CIPHER_PAD_MASK_EN
    localparam int PAD_BITS = (8 - (L % 8)) % 8;
    localparam logic [7:0] PAD_MASK = 8'(8'hFF << PAD_BITS);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t         state_reg, state_next;
    logic [WCW-1:0] word_cnt_reg, word_cnt_next;
    logic [BCW-1:0] byte_cnt_reg, byte_cnt_next;
    // Bytes of the current word that have not yet been placed on m_data.
    logic [23:0]    rest_reg, rest_next;
    logic           wait_phase_reg, wait_phase_next;
    logic           rd_en_reg, rd_en_next;
    logic [AW-1:0]  addr_reg, addr_next;
    logic [7:0]     m_data_reg, m_data_next;
    logic           m_valid_reg, m_valid_next;
    logic           m_last_reg, m_last_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;

    logic           load_byte;
    logic [BCW-1:0] load_idx;
    logic [7:0]     load_raw;
    logic           load_final;
    logic           is_last_word;
    logic           frame_end;
    logic           word_end;

    assign is_last_word = (word_cnt_reg == LAST_WORD);
    assign frame_end    = is_last_word && (byte_cnt_reg[1:0] == LAST_SLOT);
    assign word_end     = (byte_cnt_reg[1:0] == 2'd3);
    assign load_final   = (load_idx == LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            word_cnt_reg   <= '0;
            byte_cnt_reg   <= '0;
            rest_reg       <= '0;
            wait_phase_reg <= 1'b0;
            rd_en_reg      <= 1'b0;
            addr_reg       <= '0;
            m_data_reg     <= '0;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_cnt_reg   <= word_cnt_next;
            byte_cnt_reg   <= byte_cnt_next;
            rest_reg       <= rest_next;
            wait_phase_reg <= wait_phase_next;
            rd_en_reg      <= rd_en_next;
            addr_reg       <= addr_next;
            m_data_reg     <= m_data_next;
            m_valid_reg    <= m_valid_next;
            m_last_reg     <= m_last_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        word_cnt_next   = word_cnt_reg;
        byte_cnt_next   = byte_cnt_reg;
        rest_next       = rest_reg;
        wait_phase_next = wait_phase_reg;
        rd_en_next      = rd_en_reg;
        addr_next       = addr_reg;
        m_data_next     = m_data_reg;
        m_valid_next    = m_valid_reg;
        m_last_next     = m_last_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        load_byte       = 1'b0;
        load_idx        = byte_cnt_reg;
        load_raw        = 8'h00;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_ADDR;
                    word_cnt_next = '0;
                    byte_cnt_next = '0;
                    busy_next     = 1'b1;
                    rd_en_next    = 1'b1;
                end
            end
            S_ADDR: begin
                addr_next       = word_cnt_reg[AW-1:0];
                wait_phase_next = 1'b0;
                state_next      = S_WAIT;
            end
            S_WAIT: begin
                // The address leaves a register and the RAM read is registered too,
                // so q is only valid in the second WAIT cycle.
                if (!wait_phase_reg) begin
                    wait_phase_next = 1'b1;
                end else begin
                    rest_next    = cipher[23:0];
                    load_byte    = 1'b1;
                    load_idx     = byte_cnt_reg;
                    load_raw     = cipher[31:24];
                    m_valid_next = 1'b1;
                    state_next   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (m_ready) begin
                    if (frame_end) begin
                        m_valid_next = 1'b0;
                        m_last_next  = 1'b0;
                        m_data_next  = 8'h00;
                        done_next    = 1'b1;
                        state_next   = S_FIN;
                    end else if (word_end) begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                        word_cnt_next = word_cnt_reg + 1'b1;
                        m_valid_next  = 1'b0;
                        state_next    = S_ADDR;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                        rest_next     = {rest_reg[15:0], 8'h00};
                        load_byte     = 1'b1;
                        load_idx      = byte_cnt_reg + 1'b1;
                        load_raw      = rest_reg[23:16];
                    end
                end
            end
            S_FIN: begin
                busy_next  = 1'b0;
                rd_en_next = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (load_byte) begin
`ifdef CIPHER_PAD_MASK_EN
            m_data_next = load_final ? (load_raw & PAD_MASK) : load_raw;
`else
            m_data_next = load_raw;
`endif
            m_last_next = load_final;
        end
    end

    assign rd_en_c   = rd_en_reg;
    assign addr_rd_c = addr_reg;
    assign m_data    = m_data_reg;
    assign m_valid   = m_valid_reg;
    assign m_last    = m_last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_cipher_stream_reader.sv
// Scoreboard bench for cipher_stream_reader: parameter sets 1 and 4, backpressure, restart, mid-stream reset.
module tb_cipher_stream_reader;

    localparam int NB1 = 96;
    localparam int NB4 = 194;
    localparam int RD1 = 24;
    localparam int RD4 = 49;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic m_ready = 1'b0;
    int   sel = 1;

    logic start1, start4;
    assign start1 = start && (sel == 1);
    assign start4 = start && (sel == 4);

    logic        rd_en1, valid1, last1, busy1, done1;
    logic [4:0]  addr1;
    logic [31:0] cipher1;
    logic [7:0]  data1;

    logic        rd_en4, valid4, last4, busy4, done4;
    logic [5:0]  addr4;
    logic [31:0] cipher4;
    logic [7:0]  data4;

    cipher_stream_reader #(.parameter_set(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .rd_en_c(rd_en1), .addr_rd_c(addr1), .cipher(cipher1),
        .m_data(data1), .m_valid(valid1), .m_ready(m_ready), .m_last(last1),
        .busy(busy1), .done(done1)
    );

    cipher_stream_reader #(.parameter_set(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .rd_en_c(rd_en4), .addr_rd_c(addr4), .cipher(cipher4),
        .m_data(data4), .m_valid(valid4), .m_ready(m_ready), .m_last(last4),
        .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    logic [31:0] mem1 [RD1];
    logic [31:0] mem4 [RD4];

    always @(posedge clk) begin
        if (rd_en1) cipher1 <= mem1[addr1];
        if (rd_en4) cipher4 <= mem4[addr4];
    end

    logic [7:0] obs_data;
    logic       obs_valid, obs_last, obs_busy, obs_done, obs_rd_en;
    logic [5:0] obs_addr;

    always_comb begin
        obs_data  = data1;
        obs_valid = valid1;
        obs_last  = last1;
        obs_busy  = busy1;
        obs_done  = done1;
        obs_rd_en = rd_en1;
        obs_addr  = {1'b0, addr1};
        if (sel == 4) begin
            obs_data  = data4;
            obs_valid = valid4;
            obs_last  = last4;
            obs_busy  = busy4;
            obs_done  = done4;
            obs_rd_en = rd_en4;
            obs_addr  = addr4;
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_bytes [256];
    int         got;
    int         dones;
    logic       rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte k of the frame: MSB-first out of word k/4; the set-4 tail keeps only 3 valid bits.
    function automatic logic [7:0] model_byte(input int set, input int k);
        logic [31:0] w;
        logic [7:0]  b;
        w = (set == 1) ? mem1[k / 4] : mem4[k / 4];
        b = w[(31 - 8 * (k % 4)) -: 8];
`ifdef CIPHER_PAD_MASK_EN
        if (set == 4 && k == NB4 - 1) b = b & 8'hE0;
`endif
        return b;
    endfunction

    task automatic load_expected(input int set);
        int nb;
        nb = (set == 1) ? NB1 : NB4;
        for (int k = 0; k < nb; k++) exp_q.push_back(model_byte(set, k));
    endtask

    task automatic kick();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic stream(input int pat, input int restart_at, input int abort_at);
        int         cyc;
        int         last_cyc;
        int         done_cyc;
        logic       stall;
        logic       fin;
        logic [7:0] held;
        logic [7:0] e;
        cyc = 0; last_cyc = -100; done_cyc = -100;
        stall = 1'b0; fin = 1'b0; held = 8'h00;
        got = 0; dones = 0;
        while (!fin && cyc < 3000) begin
            @(posedge clk); #1;
            m_ready = (pat == 0) ? 1'b1 : rpat[cyc % 4];
            start = (cyc == restart_at);
            @(negedge clk);
            if (stall) begin
                check("stall_valid", obs_valid, 1);
                check("stall_data", obs_data, held);
            end
            stall = obs_valid && !m_ready;
            held = obs_data;
            if (obs_done) begin
                dones++;
                done_cyc = cyc;
            end
            if (obs_valid && m_ready) begin
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_bad++;
                    $error("FAIL extra_byte: observed byte %0d (%0h) expected none", got, obs_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("byte_data", obs_data, e);
                    check("byte_last", obs_last, exp_q.size() == 0);
                end
                if (got < 256) got_bytes[got] = obs_data;
                got++;
                last_cyc = cyc;
            end
            if (abort_at >= 0 && got == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_valid", obs_valid, 0);
                check("rst_data", obs_data, 0);
                check("rst_last", obs_last, 0);
                check("rst_busy", obs_busy, 0);
                check("rst_rd_en", obs_rd_en, 0);
                check("rst_addr", obs_addr, 0);
                fin = 1'b1;
            end else if (dones > 0 && cyc >= done_cyc + 6) begin
                fin = 1'b1;
            end
            cyc++;
        end
        start = 1'b0;
        check("frame_finished", fin, 1);
        if (abort_at < 0) begin
            check("done_after_last", done_cyc - last_cyc, 1);
            check("done_count", dones, 1);
        end
    endtask

    initial begin
        for (int w = 0; w < RD1; w++) mem1[w] = 32'hA500_0000 + w;
        for (int w = 0; w < RD4 - 1; w++) begin
            mem4[w] = {w[7:0], ~w[7:0], 8'h3C, w[7:0] + 8'd1};
        end
        mem4[RD4 - 1] = 32'hFFFF_FFFF;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", valid1, 0);
        check("reset_busy", busy1, 0);
        check("reset_done", done1, 0);
        check("reset_rd_en", rd_en1, 0);
        check("reset_addr", addr1, 0);
        check("reset_data", data1, 0);
        check("reset_last", last1, 0);
        check("reset_valid4", valid4, 0);
        rst = 1'b0;

        // Set 1: start latency, then a full frame with the sink always ready
        sel = 1;
        load_expected(1);
        m_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("lat_e0_valid", valid1, 0);
        check("lat_e0_busy", busy1, 1);
        @(posedge clk); #1;
        check("lat_e1_addr", addr1, 0);
        check("lat_e1_rd_en", rd_en1, 1);
        check("lat_e1_valid", valid1, 0);
        @(posedge clk); #1;
        check("lat_e2_valid", valid1, 0);
        @(posedge clk); #1;
        check("lat_e3_valid", valid1, 1);
        check("lat_e3_data", data1, 8'hA5);
        stream(0, -1, -1);
        check("set1_count", got, NB1);
        check("set1_byte0", got_bytes[0], 8'hA5);
        check("set1_byte3", got_bytes[3], 8'h00);
        check("set1_byte95", got_bytes[95], 8'h17);
        check("set1_idle_busy", busy1, 0);
        check("set1_idle_rd_en", rd_en1, 0);

        // Backpressure 1,0,0,1 with a second start while busy
        load_expected(1);
        kick();
        stream(1, 30, -1);
        check("bp_count", got, NB1);

        // Reset at byte 40, then restart from word 0
        load_expected(1);
        kick();
        stream(0, -1, 40);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_done", done1, 0);
        check("rst_hold_busy", busy1, 0);
        rst = 1'b0;
        load_expected(1);
        kick();
        stream(0, -1, -1);
        check("restart_count", got, NB1);
        check("restart_byte0", got_bytes[0], 8'hA5);

        // Set 4: partial last word and pad masking of the final byte
        sel = 4;
        load_expected(4);
        kick();
        stream(0, -1, -1);
        check("set4_count", got, NB4);
`ifdef CIPHER_PAD_MASK_EN
        check("set4_byte193", got_bytes[193], 8'hE0);
`else
        check("set4_byte193", got_bytes[193], 8'hFF);
`endif
        check("set4_byte192", got_bytes[192], 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
